// File: rtl/fetch_queue_if.sv
// fetch_queue_if: IF-to-ID prefetch queue handshake bundle
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    logic                       InValid;
    logic [WIDTH-1:0]           InInst;
    logic [WIDTH-1:0]           InPC;
    logic                       InReady;
    logic                       Stall;
    logic                       Flush;
    logic                       OutValid;
    logic [WIDTH-1:0]           OutInst;
    logic [WIDTH-1:0]           OutPC;
    logic [$clog2(DEPTH+1)-1:0] Count;

    modport master (
        output InValid, InInst, InPC, Stall, Flush,
        input  InReady, OutValid, OutInst, OutPC, Count
    );
    modport slave (
        input  InValid, InInst, InPC, Stall, Flush,
        output InReady, OutValid, OutInst, OutPC, Count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO, flushed on redirect, NOP when empty
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input logic         Clk,
    input logic         Reset,
    fetch_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] inst_q [DEPTH];
    logic [WIDTH-1:0] pc_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    always_comb begin
        q.InReady  = count_q != CW'(DEPTH);
        q.OutValid = count_q != '0;
        q.OutInst  = q.OutValid ? inst_q[rd_ptr_q] : '0;
        q.OutPC    = q.OutValid ? pc_q[rd_ptr_q] : '0;
        q.Count    = count_q;
        push       = q.InValid & q.InReady & ~q.Flush;
        pop        = q.OutValid & ~q.Stall & ~q.Flush;
        count_d    = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge Clk) begin
        if (Reset || q.Flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q  <= count_d;
        end
    end

    // storage is not cleared; outputs are gated by OutValid instead
    always_ff @(posedge Clk) begin
        if (push) begin
            inst_q[wr_ptr_q] <= q.InInst;
            pc_q[wr_ptr_q]   <= q.InPC;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue
module tb_fetch_queue;
    logic Clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

    fetch_queue_if #(.DEPTH(4), .WIDTH(32)) q ();
    fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (.Clk(Clk), .Reset(Reset), .q(q));

    always #5 Clk = ~Clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        q.InValid = v;
        q.InPC    = pc;
        q.InInst  = inst_of(pc);
    endtask

    task automatic head(input string tag, input int cnt, input logic [31:0] pc);
        chk({tag, "_count"}, 32'(q.Count), 32'(cnt));
        chk({tag, "_valid"}, 32'(q.OutValid), 32'(cnt != 0));
        chk({tag, "_pc"}, q.OutPC, cnt != 0 ? pc : 32'h0);
        chk({tag, "_inst"}, q.OutInst, cnt != 0 ? inst_of(pc) : 32'h0);
    endtask

    initial begin
        Reset = 1'b1;
        q.Stall = 1'b0;
        q.Flush = 1'b0;
        drive(1'b0, 32'h0);
        step();
        step();
        Reset = 1'b0;
        head("reset", 0, 0);
        chk("reset_ready", 32'(q.InReady), 32'd1);

        // single-entry streaming: each push is seen the next cycle
        drive(1'b1, 32'h0);
        step();
        head("s2_a", 1, 32'h0);
        drive(1'b1, 32'h4);
        step();
        head("s2_b", 1, 32'h4);
        drive(1'b1, 32'h8);
        step();
        head("s2_c", 1, 32'h8);
        drive(1'b0, 32'h0);
        step();
        head("s2_empty", 0, 0);

        // fill under stall, fifth entry held off
        q.Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h10 + 32'(4*i));
            chk("s3_ready", 32'(q.InReady), 32'(i < 4));
            step();
        end
        head("s3_full", 4, 32'h10);
        chk("s3_full_ready", 32'(q.InReady), 32'd0);
        q.Stall = 1'b0;
        step();
        head("s3_pop0", 3, 32'h14);
        chk("s3_ready_open", 32'(q.InReady), 32'd1);
        step();
        drive(1'b0, 32'h0);
        head("s3_pop1", 3, 32'h18);
        step();
        head("s3_pop2", 2, 32'h1C);
        step();
        head("s3_pop3", 1, 32'h20);
        step();
        head("s3_drained", 0, 0);

        // flush with three queued and a push offered
        q.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30 + 32'(4*i));
            step();
        end
        head("s4_pre", 3, 32'h30);
        drive(1'b1, 32'h3C);
        q.Flush = 1'b1;
        step();
        q.Flush = 1'b0;
        head("s4_flushed", 0, 0);
        chk("s4_ready", 32'(q.InReady), 32'd1);
        drive(1'b1, 32'h40);
        step();
        drive(1'b0, 32'h0);
        head("s4_sole", 1, 32'h40);
        q.Stall = 1'b0;
        step();
        head("s4_empty", 0, 0);

        // steady push+pop at occupancy 2, pointers wrap several times
        q.Stall = 1'b1;
        drive(1'b1, 32'h100);
        step();
        drive(1'b1, 32'h104);
        step();
        head("s5_pre", 2, 32'h100);
        q.Stall = 1'b0;
        for (int k = 2; k < 12; k++) begin
            drive(1'b1, 32'h100 + 32'(4*k));
            step();
            head("s5_stream", 2, 32'h100 + 32'(4*(k-1)));
        end
        drive(1'b0, 32'h0);
        step();
        head("s5_tail", 1, 32'h12C);
        step();
        head("s5_empty", 0, 0);

        // reset and flush together mid-stream
        q.Stall = 1'b1;
        drive(1'b1, 32'h200);
        step();
        drive(1'b1, 32'h204);
        step();
        head("s6_pre", 2, 32'h200);
        Reset = 1'b1;
        q.Flush = 1'b1;
        drive(1'b1, 32'h208);
        step();
        Reset = 1'b0;
        q.Flush = 1'b0;
        q.Stall = 1'b0;
        drive(1'b0, 32'h0);
        head("s6_reset", 0, 0);
        chk("s6_ready", 32'(q.InReady), 32'd1);
        step();
        head("s6_after", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
